// File: rtl/compl_sched_if.sv
// Request/operand/result bundle between the operand producers and the time-shared complement engine.
// The master drives requests, operands and modes; the slave returns the grant, status and results.
interface compl_sched_if #(
  parameter int WIDTH = 3
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       mode;
  logic [1:0]       gnt;
  logic             busy;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;

  modport master (
    output req, data0, data1, mode,
    input  gnt, busy, done, result
  );

  modport slave (
    input  req, data0, data1, mode,
    output gnt, busy, done, result
  );
endinterface

// File: rtl/compl_sched.sv
// Round-robin two-requester scheduler driving a bit-serial 1's/2's complement engine, LSB first.
// Optional macro COMPL_SCHED_MODE_EN honours the per-requester mode; when undefined, every job uses 2's complement.
module compl_sched #(
  parameter int WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  compl_sched_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_seen;
  logic             r_ptr;
  logic [1:0]       r_gnt;

  logic             w_win;
  logic             w_twos;
  logic             w_bit;
  logic             w_out;
  logic             w_last;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_win = r_ptr;
    if (bus.req == 2'b01)      w_win = 1'b0;
    else if (bus.req == 2'b10) w_win = 1'b1;
  end

`ifdef COMPL_SCHED_MODE_EN
  logic r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_mode <= 1'b0;
    else if (r_state == S_IDLE && bus.req != 2'b00) r_mode <= bus.mode[w_win];
  end

  assign w_twos = r_mode;
`else
  assign w_twos = 1'b1;
`endif

  // 2's complement passes bits through up to and including the first one, then inverts.
  assign w_bit  = r_shift[0];
  assign w_out  = w_twos ? (r_seen ? ~w_bit : w_bit) : ~w_bit;
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_seen   <= 1'b0;
      r_ptr    <= 1'b0;
      r_gnt    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            r_shift <= w_win ? bus.data1 : bus.data0;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift <= r_shift >> 1;
          r_acc   <= {w_out, r_acc[WIDTH-1:1]};
          r_seen  <= r_seen | w_bit;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // Publish the final accumulator value so result is already valid during DONE.
            r_result <= {w_out, r_acc[WIDTH-1:1]};
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_ptr   <= ~r_gnt[1];
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_DONE) ? r_gnt : 2'b00;
  assign bus.result = r_result;
endmodule

// File: tb/tb_compl_sched.sv
// Self-checking bench for compl_sched: directed vector table, contention/stability/reset sequences,
// and randomized jobs checked against an arithmetic complement model with a round-robin pointer.
module tb_compl_sched;
  localparam int W = 3;
`ifdef COMPL_SCHED_MODE_EN
  localparam bit MODE_EN = 1'b1;
`else
  localparam bit MODE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  compl_sched_if #(.WIDTH(W)) bus ();

  compl_sched #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int gnt_bad  = 0;
  logic ptr_m;

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   md;
    logic [1:0]   exp_done;
    logic [W-1:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  always @(negedge clk) if (bus.gnt == 2'b11) gnt_bad++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_compl(input logic [W-1:0] d, input bit twos);
    int m = 1 << W;
    int v = twos ? (m - int'(d)) % m : (m - 1 - int'(d));
    return W'(v);
  endfunction

  // Starts at a negedge with the DUT idle; ends one cycle after DONE, again idle.
  task automatic run_job(input logic [1:0] req, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [1:0] md, input logic [1:0] exp_done, input logic [W-1:0] exp_res,
                         input bit perturb, input logic [W-1:0] pd0, input logic [W-1:0] pd1,
                         input logic [1:0] pmd, input string tag);
    int cyc;
    bus.req = req; bus.data0 = d0; bus.data1 = d1; bus.mode = md;
    @(negedge clk);
    check({tag, "_gnt"}, bus.gnt, exp_done);
    check({tag, "_busy"}, bus.busy, 1);
    bus.req = 2'b00;
    if (perturb) begin
      bus.data0 = pd0; bus.data1 = pd1; bus.mode = pmd;
    end
    cyc = 0;
    while (bus.done == 2'b00 && cyc < 4 * W + 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, W);
    check({tag, "_done"}, bus.done, exp_done);
    check({tag, "_result"}, bus.result, exp_res);
    ptr_m = (exp_done == 2'b01);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_idle"}, {bus.busy, bus.gnt}, 0);
    check({tag, "_held"}, bus.result, exp_res);
  endtask

  initial begin
    logic [1:0]   t_done [3];
    logic [W-1:0] t_res  [3];
    int           last_done;
    int           k;
    logic [1:0]   r_req;
    logic [W-1:0] r_d0, r_d1;
    logic [1:0]   r_md;
    logic         win;

    vecs[0] = '{2'b11, 3'b001, 3'b010, 2'b11, 2'b01, 3'b111};
    vecs[1] = '{2'b01, 3'b100, 3'b000, 2'b01, 2'b01, 3'b100};
    vecs[2] = '{2'b01, 3'b000, 3'b111, 2'b11, 2'b01, 3'b000};
    vecs[3] = '{2'b10, 3'b011, 3'b101, 2'b00, 2'b10, MODE_EN ? 3'b010 : 3'b011};
    vecs[4] = '{2'b10, 3'b000, 3'b111, 2'b10, 2'b10, 3'b001};
    vecs[5] = '{2'b01, 3'b110, 3'b001, 2'b00, 2'b01, MODE_EN ? 3'b001 : 3'b010};

    // Reset with both requests pending.
    rst_n = 1'b0; bus.req = 2'b11; bus.data0 = '0; bus.data1 = '0; bus.mode = 2'b11;
    ptr_m = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.gnt, bus.busy, bus.done, bus.result}, 0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_job(vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].md, vecs[i].exp_done, vecs[i].exp_res,
              1'b0, '0, '0, 2'b00, $sformatf("vec%0d", i));

    // Operands changed right after capture must not disturb the job.
    run_job(2'b01, 3'b010, 3'b000, 2'b11, 2'b01, 3'b110, 1'b1, 3'b111, 3'b101, 2'b00, "stability");

    // Contention from a fresh reset: service alternates 0,1,0.
    rst_n = 1'b0; ptr_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 2'b11; bus.data0 = 3'b011; bus.data1 = 3'b110; bus.mode = 2'b11;
    t_done = '{2'b01, 2'b10, 2'b01};
    t_res  = '{3'b101, 3'b010, 3'b101};
    last_done = -1;
    for (int j = 0; j < 3; j++) begin
      k = 0;
      @(negedge clk);
      while (bus.done == 2'b00 && k < 4 * W + 10) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("cont%0d_done", j), bus.done, t_done[j]);
      check($sformatf("cont%0d_result", j), bus.result, t_res[j]);
      if (j > 0) check($sformatf("cont%0d_period", j), k + 1, W + 2);
      last_done = j;
    end
    bus.req = 2'b00;
    repeat (3) @(negedge clk);
    check("cont_idle", bus.busy, 0);
    ptr_m = 1'b1;

    // Reset during the second SHIFT cycle aborts the job.
    bus.req = 2'b01; bus.data0 = 3'b011; bus.mode = 2'b11;
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_async", {bus.gnt, bus.busy, bus.done, bus.result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 1'b0;
    k = 0;
    repeat (2 * W + 2) begin
      @(negedge clk);
      if (bus.done != 2'b00) k++;
    end
    check("midrst_no_done", k, 0);
    check("midrst_result", bus.result, 0);
    run_job(2'b10, 3'b000, 3'b100, 2'b11, 2'b10, 3'b100, 1'b0, '0, '0, 2'b00, "post_rst");

    // Randomized jobs against the arithmetic model and round-robin pointer.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = 2'b00;
        @(negedge clk);
        check($sformatf("rnd%0d_noreq", n), {bus.busy, bus.gnt}, 0);
      end
      r_req = 2'($urandom_range(1, 3));
      r_d0  = W'($urandom);
      r_d1  = W'($urandom);
      r_md  = 2'($urandom);
      win   = (r_req == 2'b11) ? ptr_m : r_req[1];
      run_job(r_req, r_d0, r_d1, r_md, win ? 2'b10 : 2'b01,
              ref_compl(win ? r_d1 : r_d0, MODE_EN ? r_md[win] : 1'b1),
              1'($urandom), W'($urandom), W'($urandom), 2'($urandom), $sformatf("rnd%0d", n));
    end

    check("cont_all_seen", last_done, 2);
    check("gnt_never_both", gnt_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
